// File: rtl/easyaxi_mst_wdata_sched.sv
`default_nettype none
// ============================================================================
// Module   : easyaxi_mst_wdata_sched
// Purpose  : W-channel sequencer for the AXI write master. Accepted AW
//            requests are queued in handshake order; bursts are replayed
//            one at a time as W beats (address-derived data, strobes, last).
//            Each wlast handshake produces a one-cycle completion pulse that
//            carries the slot pointer of the finished burst.
// Ports    : aw_fire/aw_*        accepted AW request (push side)
//            aw_room             queue not full
//            axi_mst_w*          AXI W channel (master side)
//            wr_comp_vld/_ptr    completion pulse and slot pointer
//            busy                work queued or burst in flight
//            ovf_err             sticky: AW arrived while queue full
// Options  : EASYAXI_WSTRB_ALIGN_EN - size-aligned strobes (else all ones)
// Revision : 1.0 - initial release
// ============================================================================

`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 8
`endif

module easyaxi_mst_wdata_sched #(
    parameter int OST_DEPTH   = 16,
    parameter int QUEUE_DEPTH = 8,
    localparam int PTR_W      = (OST_DEPTH == 1) ? 1 : $clog2(OST_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      aw_fire,
    input  logic [PTR_W-1:0]          aw_ptr,
    input  logic [`AXI_ADDR_W-1:0]    aw_addr,
    input  logic [`AXI_LEN_W-1:0]     aw_len,
    input  logic [`AXI_SIZE_W-1:0]    aw_size,
    input  logic [`AXI_BURST_W-1:0]   aw_burst,
    output logic                      aw_room,
    output logic                      axi_mst_wvalid,
    input  logic                      axi_mst_wready,
    output logic [`AXI_DATA_W-1:0]    axi_mst_wdata,
    output logic [`AXI_DATA_W/8-1:0]  axi_mst_wstrb,
    output logic                      axi_mst_wlast,
    output logic [`AXI_USER_W-1:0]    axi_mst_wuser,
    output logic                      wr_comp_vld,
    output logic [PTR_W-1:0]          wr_comp_ptr,
    output logic                      busy,
    output logic                      ovf_err
);

    localparam int ADDR_W = `AXI_ADDR_W;
    localparam int LEN_W  = `AXI_LEN_W;
    localparam int SIZE_W = `AXI_SIZE_W;
    localparam int BRST_W = `AXI_BURST_W;
    localparam int DATA_W = `AXI_DATA_W;
    localparam int USER_W = `AXI_USER_W;
    localparam int STRB_W = DATA_W / 8;
    localparam int QA_W   = $clog2(QUEUE_DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    // Queue storage (no reset needed: validity is tracked by the pointers)
    logic [PTR_W-1:0]  r_q_ptr   [QUEUE_DEPTH];
    logic [ADDR_W-1:0] r_q_addr  [QUEUE_DEPTH];
    logic [LEN_W-1:0]  r_q_len   [QUEUE_DEPTH];
    logic [SIZE_W-1:0] r_q_size  [QUEUE_DEPTH];
    logic [BRST_W-1:0] r_q_burst [QUEUE_DEPTH];

    logic [QA_W:0]     r_wr_ptr, r_rd_ptr;
    logic [0:0]        r_state, w_state_nxt;
    logic [PTR_W-1:0]  r_cur_ptr;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [LEN_W-1:0]  r_cur_len;
    logic [SIZE_W-1:0] r_cur_size;
    logic [BRST_W-1:0] r_cur_burst;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic              r_comp_vld;
    logic [PTR_W-1:0]  r_comp_ptr;
    logic              r_ovf;

    logic              w_full, w_empty, w_push, w_pop;
    logic              w_beat_hs, w_last;
    logic [ADDR_W-1:0] w_step, w_bound, w_next_addr;

    // Extra wrap bit distinguishes full from empty when low bits match
    assign w_full    = (r_wr_ptr[QA_W] != r_rd_ptr[QA_W]) &&
                       (r_wr_ptr[QA_W-1:0] == r_rd_ptr[QA_W-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    // A pop in the same cycle never frees room for a push into a full queue
    assign w_push    = aw_fire & ~w_full;
    assign w_last    = (r_state == S_BURST) && (r_beat_cnt == r_cur_len);
    assign w_beat_hs = axi_mst_wvalid & axi_mst_wready;

    // ---------------- next-state process ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (w_beat_hs && w_last) begin
                    // Chain straight into the next burst when one is waiting
                    if (!w_empty) w_pop = 1'b1;
                    else          w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------- beat address generation ----------------
    always_comb begin
        w_step  = ADDR_W'(1) << r_cur_size;
        w_bound = (ADDR_W'(r_cur_len) + ADDR_W'(1)) << r_cur_size;
        case (r_cur_burst)
            2'b00:   w_next_addr = r_cur_addr;
            2'b10:   w_next_addr = (r_cur_addr & ~(w_bound - ADDR_W'(1))) |
                                   ((r_cur_addr + w_step) & (w_bound - ADDR_W'(1)));
            default: w_next_addr = r_cur_addr + w_step;
        endcase
    end

    // ---------------- queue and burst datapath ----------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_ptr  [r_wr_ptr[QA_W-1:0]] <= aw_ptr;
            r_q_addr [r_wr_ptr[QA_W-1:0]] <= aw_addr;
            r_q_len  [r_wr_ptr[QA_W-1:0]] <= aw_len;
            r_q_size [r_wr_ptr[QA_W-1:0]] <= aw_size;
            r_q_burst[r_wr_ptr[QA_W-1:0]] <= aw_burst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cur_ptr   <= '0;
            r_cur_addr  <= '0;
            r_cur_len   <= '0;
            r_cur_size  <= '0;
            r_cur_burst <= '0;
            r_beat_cnt  <= '0;
            r_comp_vld  <= 1'b0;
            r_comp_ptr  <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_push)            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (aw_fire && w_full) r_ovf    <= 1'b1;
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_cur_ptr   <= r_q_ptr  [r_rd_ptr[QA_W-1:0]];
                r_cur_addr  <= r_q_addr [r_rd_ptr[QA_W-1:0]];
                r_cur_len   <= r_q_len  [r_rd_ptr[QA_W-1:0]];
                r_cur_size  <= r_q_size [r_rd_ptr[QA_W-1:0]];
                r_cur_burst <= r_q_burst[r_rd_ptr[QA_W-1:0]];
                r_beat_cnt  <= '0;
            end else if (w_beat_hs && !w_last) begin
                r_beat_cnt  <= r_beat_cnt + 1'b1;
                r_cur_addr  <= w_next_addr;
            end
            r_comp_vld <= w_beat_hs & w_last;
            if (w_beat_hs && w_last) r_comp_ptr <= r_cur_ptr;
        end
    end

    // ---------------- output process ----------------
`ifdef EASYAXI_WSTRB_ALIGN_EN
    logic [15:0] w_lane_lo, w_lane_step, w_lane_hi;
    always_comb begin
        w_lane_lo   = 16'(r_cur_addr) & 16'(STRB_W - 1);
        w_lane_step = 16'(1) << r_cur_size;
        w_lane_hi   = (w_lane_lo & ~(w_lane_step - 16'd1)) + w_lane_step - 16'd1;
    end
`endif

    always_comb begin
        axi_mst_wvalid = (r_state == S_BURST);
        axi_mst_wlast  = w_last;
        axi_mst_wdata  = '0;
        axi_mst_wstrb  = '0;
        axi_mst_wuser  = '0;
        if (r_state == S_BURST) begin
            axi_mst_wdata = DATA_W'(r_cur_addr) ^ (DATA_W'(r_beat_cnt) << 24);
            axi_mst_wuser = USER_W'(r_cur_ptr);
`ifdef EASYAXI_WSTRB_ALIGN_EN
            for (int i = 0; i < STRB_W; i++) begin
                axi_mst_wstrb[i] = (16'(i) >= w_lane_lo) && (16'(i) <= w_lane_hi);
            end
`else
            axi_mst_wstrb = '1;
`endif
        end
    end

    assign aw_room     = ~w_full;
    assign wr_comp_vld = r_comp_vld;
    assign wr_comp_ptr = r_comp_ptr;
    assign busy        = ~w_empty | (r_state == S_BURST);
    assign ovf_err     = r_ovf;

endmodule

`default_nettype wire
